ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DEPTH, 128, number of valid RAM words; addresses >= DEPTH are out of range.
REQ-002 Parameter: DATA_W, 16, data and address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  requester A transaction request; held high until a_done.
REQ-006 a_we  input  1  requester A: 1 = write, 0 = read; stable while a_req is high.
REQ-007 a_addr  input  DATA_W  requester A word address; stable while a_req is high.
REQ-008 a_wdata  input  DATA_W  requester A write data; stable while a_req is high.
REQ-009 a_gnt  output  1  high for the single ACCESS cycle of A's transaction.
REQ-010 a_done  output  1  one-cycle completion pulse to A.
REQ-011 a_err  output  1  valid with a_done; 1 = address out of range, RAM untouched.
REQ-012 a_rdata  output  DATA_W  read result for A; valid with a_done on reads and held until A's next done.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_err, b_rdata: same directions, widths and meaning as REQ-005..012, for requester B.
REQ-014 ram_read_addr  output  DATA_W  RAM read address.
REQ-015 ram_write_addr  output  DATA_W  RAM write address.
REQ-016 ram_write_data  output  DATA_W  RAM write data.
REQ-017 ram_read_en  output  1  RAM read enable.
REQ-018 ram_write_en  output  1  RAM write enable; RAM writes on the clk rising edge while this is high.
REQ-019 ram_read_data  input  DATA_W  RAM combinational read data.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE; transitions IDLE->ACCESS when any req is high, ACCESS->DONE always, DONE->IDLE always.
REQ-021 Arbitration occurs only in IDLE; a winner and its we/addr/wdata are latched into internal registers on the IDLE->ACCESS edge.
REQ-022 Round-robin: if only one req is high, it wins; if both are high, the requester not granted last wins; the last-granted pointer updates on every grant.
REQ-023 ACCESS, in range, write: ram_write_en=1, ram_write_addr/ram_write_data = latched values; write commits on the edge ending ACCESS.
REQ-024 ACCESS, in range, read: ram_read_en=1, ram_read_addr = latched addr; ram_read_data is captured into the winner's rdata register on the edge ending ACCESS.
REQ-025 ACCESS, out of range (addr >= DEPTH): ram_read_en=0 and ram_write_en=0; err is set and rdata is unchanged.
REQ-026 Outside ACCESS: ram_read_en=0, ram_write_en=0, and the RAM address/data outputs hold their last values.
REQ-027 The winner's gnt is high only in ACCESS; its done and err are high only in DONE; the loser's gnt, done and err stay 0.
REQ-028 err is 0 in DONE for in-range transactions; on writes, rdata keeps its previous value.
REQ-029 Latency: request sampled in IDLE at edge N -> gnt during cycle N+1 -> done during cycle N+2; 3-cycle transaction period per grant.
REQ-030 req is ignored in ACCESS and DONE; a req still high when the FSM returns to IDLE starts a new transaction (the requester drops req in the cycle after done).
REQ-031 Continuous requests from both ports: grants strictly alternate A,B,A,B; neither port waits more than one transaction.
REQ-032 Changes to we/addr/wdata after the grant have no effect on the transaction in flight.

Reset
REQ-033 When rst_n=0: state IDLE; all gnt/done/err outputs 0; ram_read_en and ram_write_en 0 immediately, without waiting for clk; rdata registers 0; RAM address/data outputs 0; last-granted pointer = B, so A wins the first tie.
REQ-034 Reset asserted during ACCESS aborts the transaction: no RAM write occurs unless the commit edge precedes the reset, and no done is issued.
REQ-035 The first arbitration after reset release occurs on the first rising edge with rst_n=1.

Verification
REQ-036 Reset, then A writes 0x1234 to addr 5 -> a_gnt in cycle 1, ram_write_en=1 with addr 5/data 0x1234, a_done in cycle 2, a_err=0.
REQ-037 B then reads addr 5 -> b_done with b_rdata=0x1234; a_rdata unchanged.
REQ-038 A and B both request in the same cycle right after reset -> A granted first, B granted on the next IDLE; with continuous requests, grants alternate A,B,A,B over 8 transactions.
REQ-039 A writes addr 128 (0x0080) -> a_done with a_err=1, ram_write_en stays 0; a later read of addr 0 returns its prior contents.
REQ-040 rst_n pulled low mid-ACCESS of a B write to addr 7 (value 0xBEEF) -> ram_write_en drops at once, no b_done; after reset, a read of addr 7 does not return 0xBEEF.
REQ-041 A changes a_addr from 3 to 9 during its own ACCESS -> the RAM sees addr 3 only.

Source files
------------

// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter giving requesters A and B exclusive access to one single-port-style RAM.
// Latency: grant one cycle after the request is sampled, done one cycle later; 3-cycle period per grant.
// Backpressure: a requester holds req until its done pulse; the losing requester waits at most one transaction.
module ram_arbiter #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_read_addr,
    output logic [DATA_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_en,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // One extra bit so a DEPTH equal to 2**DATA_W still compares correctly.
    localparam logic [DATA_W:0] DEPTH_LIM = (DATA_W+1)'(DEPTH);

    state_t state;
    logic   last_b;
    logic   win_b;
    logic   lat_we;
    logic   lat_oor;

    logic              pick_b;
    logic              sel_we;
    logic              sel_oor;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        pick_b    = b_req && (!a_req || !last_b);
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);
    end

    // The RAM address/data registers double as the latched transaction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_b         <= 1'b1;
            win_b          <= 1'b0;
            lat_we         <= 1'b0;
            lat_oor        <= 1'b0;
            a_gnt          <= 1'b0;
            a_done         <= 1'b0;
            a_err          <= 1'b0;
            a_rdata        <= '0;
            b_gnt          <= 1'b0;
            b_done         <= 1'b0;
            b_err          <= 1'b0;
            b_rdata        <= '0;
            ram_read_addr  <= '0;
            ram_write_addr <= '0;
            ram_write_data <= '0;
            ram_read_en    <= 1'b0;
            ram_write_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state   <= ACCESS;
                        last_b  <= pick_b;
                        win_b   <= pick_b;
                        lat_we  <= sel_we;
                        lat_oor <= sel_oor;
                        a_gnt   <= !pick_b;
                        b_gnt   <= pick_b;
                        if (!sel_oor) begin
                            if (sel_we) begin
                                ram_write_en   <= 1'b1;
                                ram_write_addr <= sel_addr;
                                ram_write_data <= sel_wdata;
                            end else begin
                                ram_read_en   <= 1'b1;
                                ram_read_addr <= sel_addr;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state        <= DONE;
                    a_gnt        <= 1'b0;
                    b_gnt        <= 1'b0;
                    ram_read_en  <= 1'b0;
                    ram_write_en <= 1'b0;
                    a_done       <= !win_b;
                    b_done       <= win_b;
                    a_err        <= !win_b && lat_oor;
                    b_err        <= win_b && lat_oor;
                    if (!lat_oor && !lat_we) begin
                        if (win_b) b_rdata <= ram_read_data;
                        else       a_rdata <= ram_read_data;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    a_done <= 1'b0;
                    a_err  <= 1'b0;
                    b_done <= 1'b0;
                    b_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 128-word RAM attached.
// Latency: checks fixed gnt/done cycles; Backpressure: requests held until done, two-port contention exercised.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        a_gnt, a_done, a_err;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        b_gnt, b_done, b_err;
    logic [15:0] b_rdata;
    logic [15:0] ram_read_addr, ram_write_addr, ram_write_data, ram_read_data;
    logic        ram_read_en, ram_write_en;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:127];

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'hA000 + 16'(i);
    end

    always @(posedge clk) if (ram_write_en) mem[ram_write_addr[6:0]] <= ram_write_data;
    assign ram_read_data = mem[ram_read_addr[6:0]];

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_read_en(ram_read_en),
        .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the FSM in IDLE; returns the same way.
    task automatic xact(input string tag, input bit pb, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, input bit exp_err, input logic [15:0] exp_rd);
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        @(posedge clk); #1;
        chk({tag, ".gnt"}, 16'({a_gnt, b_gnt}), pb ? 16'd1 : 16'd2);
        chk({tag, ".en"}, 16'({ram_write_en, ram_read_en}),
            16'({we && !exp_err, !we && !exp_err}));
        if (!exp_err && we) begin
            chk({tag, ".waddr"}, ram_write_addr, addr);
            chk({tag, ".wdata"}, ram_write_data, wd);
        end
        if (!exp_err && !we) chk({tag, ".raddr"}, ram_read_addr, addr);
        @(posedge clk); #1;
        chk({tag, ".done"}, 16'({a_done, b_done}), pb ? 16'd1 : 16'd2);
        chk({tag, ".err"}, 16'({a_err, b_err}), pb ? 16'(exp_err) : 16'({exp_err, 1'b0}));
        chk({tag, ".rdata"}, pb ? b_rdata : a_rdata, exp_rd);
        chk({tag, ".idle_en"}, 16'({ram_write_en, ram_read_en, a_gnt, b_gnt}), 16'd0);
        a_req = 0; b_req = 0;
        @(posedge clk); #1;
        chk({tag, ".done_clr"}, 16'({a_done, b_done, a_err, b_err}), 16'd0);
    endtask

    initial begin
        #2;
        chk("rst.ctl", 16'({a_gnt, a_done, a_err, b_gnt, b_done, b_err, ram_read_en, ram_write_en}), 16'd0);
        chk("rst.a_rdata", a_rdata, 16'h0000);
        chk("rst.b_rdata", b_rdata, 16'h0000);
        chk("rst.waddr", ram_write_addr, 16'h0000);
        chk("rst.wdata", ram_write_data, 16'h0000);
        chk("rst.raddr", ram_read_addr, 16'h0000);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        xact("a_wr5",    0, 1, 16'd5,    16'h1234, 0, 16'h0000);
        chk("mem5", mem[5], 16'h1234);
        xact("b_rd5",    1, 0, 16'd5,    16'h0000, 0, 16'h1234);
        chk("a_rdata_kept", a_rdata, 16'h0000);
        xact("b_wr127",  1, 1, 16'd127,  16'h5A5A, 0, 16'h1234);
        xact("a_rd127",  0, 0, 16'd127,  16'h0000, 0, 16'h5A5A);
        xact("a_wr128",  0, 1, 16'h0080, 16'hDEAD, 1, 16'h5A5A);
        xact("a_rd0",    0, 0, 16'd0,    16'h0000, 0, 16'hA000);
        xact("a_rd200",  0, 0, 16'd200,  16'h0000, 1, 16'hA000);
        xact("b_rd128",  1, 0, 16'd128,  16'h0000, 1, 16'h1234);

        // Simultaneous continuous requests straight out of reset.
        @(negedge clk); rst_n = 0;
        #1;
        chk("rst2.rdata", 16'(a_rdata | b_rdata), 16'h0000);
        a_req = 1; a_we = 0; a_addr = 16'd1;
        b_req = 1; b_we = 0; b_addr = 16'd2;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d.gnt", i), 16'({a_gnt, b_gnt}), (i % 2 == 0) ? 16'd2 : 16'd1);
            @(posedge clk); #1;
            chk($sformatf("rr%0d.done", i), 16'({a_done, b_done}), (i % 2 == 0) ? 16'd2 : 16'd1);
            chk($sformatf("rr%0d.rdata", i), (i % 2 == 0) ? a_rdata : b_rdata,
                (i % 2 == 0) ? 16'hA001 : 16'hA002);
            @(posedge clk); #1;
        end
        a_req = 0; b_req = 0;

        // Reset in the middle of a B write must abort it.
        b_req = 1; b_we = 1; b_addr = 16'd7; b_wdata = 16'hBEEF;
        @(posedge clk); #1;
        chk("abort.pre_en", 16'({b_gnt, ram_write_en}), 16'd3);
        #2; rst_n = 0; b_req = 0;
        #1;
        chk("abort.en_drop", 16'({ram_write_en, b_gnt}), 16'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort.no_done", 16'({b_done, a_done}), 16'd0);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        xact("a_rd7",    0, 0, 16'd7,    16'h0000, 0, 16'hA007);
        xact("b_rd5b",   1, 0, 16'd5,    16'h0000, 0, 16'h1234);

        // Address/data change during ACCESS must not reach the RAM.
        a_req = 1; a_we = 1; a_addr = 16'd3; a_wdata = 16'h3333;
        @(posedge clk); #1;
        a_addr = 16'd9; a_wdata = 16'h9999;
        #2;
        chk("chg.waddr", ram_write_addr, 16'd3);
        chk("chg.wdata", ram_write_data, 16'h3333);
        @(posedge clk); #1;
        chk("chg.done", 16'({a_done, a_err}), 16'd2);
        a_req = 0;
        @(posedge clk); #1;
        xact("a_rd3",    0, 0, 16'd3,    16'h0000, 0, 16'h3333);
        xact("a_rd9",    0, 0, 16'd9,    16'h0000, 0, 16'hA009);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
